branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_pkg.sv | 30 +++
 rtl/branch_ctrl_if.sv | 37 +++
 rtl/branch_cond_eval.sv | 22 ++
 rtl/sync_rst_dff.sv | 18 +
 rtl/branch_ctrl.sv | 112 +++++++++++
 5 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared types for the conditional-branch controller: operand width, branch
// condition encodings, FSM state encodings and the saturating-count helper.
package branch_ctrl_pkg;

    localparam int XLEN = 16;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t WORD_ZERO = '0;
    localparam word_t CNT_MAX   = '1;

    typedef enum logic [1:0] {
        BR_BEQZ = 2'b00,
        BR_BNEZ = 2'b01,
        BR_BLTZ = 2'b10,
        BR_BGEZ = 2'b11
    } br_op_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT_RS  = 2'b01,
        S_EVAL     = 2'b10,
        S_REDIRECT = 2'b11
    } state_t;

    function automatic word_t sat_inc(input word_t v);
        return (v == CNT_MAX) ? v : word_t'(v + word_t'(1));
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode/fetch-side bundle of the branch controller: branch request, Rs operand,
// redirect handshake, squash/retire pulses and statistics.
interface branch_ctrl_if;
    import branch_ctrl_pkg::*;

    logic   br_valid;
    br_op_t br_op;
    word_t  br_pc_inc;
    word_t  br_imm;
    word_t  rs_data;
    logic   rs_ready;
    logic   redirect_ready;
    logic   cnt_clr;

    logic   br_stall;
    logic   redirect_valid;
    word_t  redirect_pc;
    logic   flush;
    logic   br_done;
    word_t  taken_cnt;
    word_t  ntaken_cnt;

    modport master (
        output br_valid, br_op, br_pc_inc, br_imm, rs_data, rs_ready,
               redirect_ready, cnt_clr,
        input  br_stall, redirect_valid, redirect_pc, flush, br_done,
               taken_cnt, ntaken_cnt
    );

    modport slave (
        input  br_valid, br_op, br_pc_inc, br_imm, rs_data, rs_ready,
               redirect_ready, cnt_clr,
        output br_stall, redirect_valid, redirect_pc, flush, br_done,
               taken_cnt, ntaken_cnt
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition decode on the latched Rs value.
// Latency: zero cycles; no backpressure.
module branch_cond_eval
    import branch_ctrl_pkg::*;
(
    input  word_t  rs,
    input  br_op_t op,
    output logic   taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            BR_BEQZ: taken = (rs == WORD_ZERO);
            BR_BNEZ: taken = (rs != WORD_ZERO);
            BR_BLTZ: taken = rs[XLEN-1];
            BR_BGEZ: taken = ~rs[XLEN-1];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/sync_rst_dff.sv
// Generic register cell with synchronous active-high reset to RST_VAL.
// Latency: one clock; no backpressure.
module sync_rst_dff #(
    parameter type T       = logic,
    parameter T    RST_VAL = T'('0)
) (
    input  logic clk,
    input  logic rst,
    input  T     d,
    output T     q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/branch_ctrl.sv
// Resolves one conditional branch at a time: waits for Rs, evaluates, then offers a
// redirect to fetch. Not-taken retires 1 cycle after issue, taken redirects at cycle 2;
// decode is stalled while busy and the redirect holds until fetch accepts it.
module branch_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    branch_ctrl_if.slave bus
);

    state_t state_q, state_d;
    br_op_t op_q, op_d;
    word_t  pc_inc_q, pc_inc_d;
    word_t  imm_q, imm_d;
    word_t  rs_q, rs_d;
    word_t  target_q, target_d;
    word_t  taken_cnt_q, taken_cnt_d;
    word_t  ntaken_cnt_q, ntaken_cnt_d;

    logic taken;
    logic inc_taken, inc_ntaken;
    logic done_c, flush_c, rv_c;

    branch_cond_eval u_cond (.rs(rs_q), .op(op_q), .taken(taken));

    sync_rst_dff #(.T(state_t), .RST_VAL(S_IDLE))    u_state      (.clk(clk), .rst(rst), .d(state_d),      .q(state_q));
    sync_rst_dff #(.T(br_op_t), .RST_VAL(BR_BEQZ))   u_op         (.clk(clk), .rst(rst), .d(op_d),         .q(op_q));
    sync_rst_dff #(.T(word_t),  .RST_VAL(WORD_ZERO)) u_pc_inc     (.clk(clk), .rst(rst), .d(pc_inc_d),     .q(pc_inc_q));
    sync_rst_dff #(.T(word_t),  .RST_VAL(WORD_ZERO)) u_imm        (.clk(clk), .rst(rst), .d(imm_d),        .q(imm_q));
    sync_rst_dff #(.T(word_t),  .RST_VAL(WORD_ZERO)) u_rs         (.clk(clk), .rst(rst), .d(rs_d),         .q(rs_q));
    sync_rst_dff #(.T(word_t),  .RST_VAL(WORD_ZERO)) u_target     (.clk(clk), .rst(rst), .d(target_d),     .q(target_q));
    sync_rst_dff #(.T(word_t),  .RST_VAL(WORD_ZERO)) u_taken_cnt  (.clk(clk), .rst(rst), .d(taken_cnt_d),  .q(taken_cnt_q));
    sync_rst_dff #(.T(word_t),  .RST_VAL(WORD_ZERO)) u_ntaken_cnt (.clk(clk), .rst(rst), .d(ntaken_cnt_d), .q(ntaken_cnt_q));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pc_inc_d   = pc_inc_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        target_d   = target_q;
        inc_taken  = 1'b0;
        inc_ntaken = 1'b0;
        done_c     = 1'b0;
        flush_c    = 1'b0;
        rv_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.br_valid) begin
                    op_d     = bus.br_op;
                    pc_inc_d = bus.br_pc_inc;
                    imm_d    = bus.br_imm;
                    if (bus.rs_ready) begin
                        rs_d    = bus.rs_data;
                        state_d = S_EVAL;
                    end else begin
                        state_d = S_WAIT_RS;
                    end
                end
            end
            S_WAIT_RS: begin
                if (bus.rs_ready) begin
                    rs_d    = bus.rs_data;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (taken) begin
                    inc_taken = 1'b1;
                    target_d  = word_t'(pc_inc_q + imm_q);
                    state_d   = S_REDIRECT;
                end else begin
                    inc_ntaken = 1'b1;
                    done_c     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_REDIRECT: begin
                rv_c = 1'b1;
                if (bus.redirect_ready) begin
                    flush_c = 1'b1;
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A reset cycle must not leak a squash or retire pulse from whatever state we were in.
        if (rst) begin
            done_c  = 1'b0;
            flush_c = 1'b0;
            rv_c    = 1'b0;
        end

        taken_cnt_d  = bus.cnt_clr ? WORD_ZERO
                     : (inc_taken ? sat_inc(taken_cnt_q) : taken_cnt_q);
        ntaken_cnt_d = bus.cnt_clr ? WORD_ZERO
                     : (inc_ntaken ? sat_inc(ntaken_cnt_q) : ntaken_cnt_q);
    end

    assign bus.br_stall       = (state_q != S_IDLE);
    assign bus.redirect_valid = rv_c;
    assign bus.redirect_pc    = target_q;
    assign bus.flush          = flush_c;
    assign bus.br_done        = done_c;
    assign bus.taken_cnt      = taken_cnt_q;
    assign bus.ntaken_cnt     = ntaken_cnt_q;

endmodule
